// File: rtl/branch_hazard_controller.sv
// ID-stage branch hazard controller for the 5-stage 16-bit pipeline.
// Detects branch-operand and load-use hazards and stalls PC and IF/ID.
// Flushes IF/ID on taken branches and jumps.
// Keeps saturating counters for branches, flushes and stall cycles.
module branch_hazard_controller #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Freeze,
  input  logic              ID_Branch,
  input  logic              ID_Jump,
  input  logic              ID_ReadsRs,
  input  logic              ID_ReadsRt,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              MEM_MemRead,
  input  logic [REG_AW-1:0] MEM_Rd,
  input  logic              CompTaken,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic [CNT_W-1:0]  BranchCount,
  output logic [CNT_W-1:0]  FlushCount,
  output logic [CNT_W-1:0]  StallCycles
);

  // StStall holds the single remaining cycle of a depth-2 stall.
  typedef enum logic [1:0] {StRun, StStall, StShadow} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic match_ex, match_mem;
  logic depth2, depth1;
  logic taken;
  logic do_stall, do_resolve, do_flush;

  // Operand match against EX and MEM destinations; register 0 never matches.
  always_comb begin
    match_ex  = (ID_ReadsRs && (EX_Rd == ID_Rs) && (EX_Rd != '0)) ||
                (ID_ReadsRt && (EX_Rd == ID_Rt) && (EX_Rd != '0));
    match_mem = (ID_ReadsRs && (MEM_Rd == ID_Rs) && (MEM_Rd != '0)) ||
                (ID_ReadsRt && (MEM_Rd == ID_Rt) && (MEM_Rd != '0));
    // A jump (even paired with a branch) never stalls.
    depth2 = !ID_Jump && ID_Branch && EX_MemRead && match_ex;
    depth1 = !ID_Jump && ((ID_Branch && EX_RegWrite && !EX_MemRead && match_ex) ||
                          (ID_Branch && MEM_MemRead && match_mem) ||
                          (EX_MemRead && match_ex));
    taken  = (ID_Branch && CompTaken) || ID_Jump;
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    do_stall    = 1'b0;
    do_resolve  = 1'b0;
    do_flush    = 1'b0;
    if (reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      state_d     = StRun;
    end else if (Freeze) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (depth2 || depth1) begin
            do_stall = 1'b1;
            if (depth2) state_d = StStall;
          end else if (ID_Branch || ID_Jump) begin
            do_resolve = 1'b1;
            if (taken) begin
              do_flush = 1'b1;
              state_d  = StShadow;
            end
          end
        end
        StStall: begin
          do_stall = 1'b1;
          state_d  = StRun;
        end
        StShadow: state_d = StRun;
        default:  state_d = StRun;
      endcase
      if (do_stall) begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
      // Flush overrides the IF/ID load even though IFID_Write stays high.
      if (do_flush) IFID_Flush = 1'b1;
    end
  end

  // Saturating counter increments.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (do_resolve && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (do_flush && (flush_cnt_q != '1))    flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    if (do_stall && (stall_cnt_q != '1))    stall_cnt_d  = stall_cnt_q + CNT_W'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      branch_cnt_q <= '0;
      flush_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign FlushCount  = flush_cnt_q;
  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed bench for branch_hazard_controller. A second instance with 4-bit
// counters shares the stimulus so counter saturation is reachable quickly.
module tb_branch_hazard_controller;

  logic clk = 1'b0;
  logic reset, Freeze, ID_Branch, ID_Jump, ID_ReadsRs, ID_ReadsRt;
  logic [3:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic EX_RegWrite, EX_MemRead, MEM_MemRead, CompTaken;
  logic PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble;
  logic [15:0] BranchCount, FlushCount, StallCycles;
  logic s_PCWrite, s_IFID_Write, s_IFID_Flush, s_IDEX_Bubble;
  logic [3:0] s_BranchCount, s_FlushCount, s_StallCycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_hazard_controller #(.REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Freeze(Freeze), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
    .ID_ReadsRs(ID_ReadsRs), .ID_ReadsRt(ID_ReadsRt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .CompTaken(CompTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .BranchCount(BranchCount), .FlushCount(FlushCount),
    .StallCycles(StallCycles)
  );

  branch_hazard_controller #(.REG_AW(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .Freeze(Freeze), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
    .ID_ReadsRs(ID_ReadsRs), .ID_ReadsRt(ID_ReadsRt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .CompTaken(CompTaken),
    .PCWrite(s_PCWrite), .IFID_Write(s_IFID_Write), .IFID_Flush(s_IFID_Flush),
    .IDEX_Bubble(s_IDEX_Bubble), .BranchCount(s_BranchCount), .FlushCount(s_FlushCount),
    .StallCycles(s_StallCycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble}.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {28'd0, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble}, {28'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int b, input int f, input int s);
    chk({tag, "_branch"}, {16'd0, BranchCount}, b);
    chk({tag, "_flush"},  {16'd0, FlushCount},  f);
    chk({tag, "_stall"},  {16'd0, StallCycles}, s);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Freeze = 0; ID_Branch = 0; ID_Jump = 0; ID_ReadsRs = 0; ID_ReadsRt = 0;
    ID_Rs = 0; ID_Rt = 0; EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0;
    MEM_MemRead = 0; MEM_Rd = 0; CompTaken = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    chk_out("reset_outputs", 4'b0011);
    cyc();
    reset = 0;
    chk_cnt("after_reset", 0, 0, 0);
    chk_out("run_idle", 4'b1100);

    // Taken branch, no hazard: immediate flush, then shadow ignores a branch.
    ID_Branch = 1; CompTaken = 1;
    chk_out("taken_branch", 4'b1110);
    cyc();
    chk_cnt("after_taken", 1, 1, 0);
    chk_out("shadow_ignores_branch", 4'b1100);
    cyc();
    chk_cnt("after_shadow", 1, 1, 0);
    idle();

    // Branch on a load result in EX: two stall cycles, then not-taken resolve.
    ID_Branch = 1; ID_ReadsRs = 1; ID_Rs = 3;
    EX_MemRead = 1; EX_RegWrite = 1; EX_Rd = 3;
    chk_out("depth2_stall1", 4'b0001);
    cyc();
    chk_out("depth2_stall2", 4'b0001);
    cyc();
    EX_MemRead = 0; EX_RegWrite = 0;
    chk_cnt("after_depth2", 1, 1, 2);
    chk_out("resolve_not_taken", 4'b1100);
    cyc();
    chk_cnt("after_not_taken", 2, 1, 2);
    idle();

    // Load-use on Rt for a non-branch: one stall; register 0 never hazards.
    ID_ReadsRt = 1; ID_Rt = 5; EX_MemRead = 1; EX_Rd = 5;
    chk_out("load_use_stall", 4'b0001);
    cyc();
    chk("load_use_count", {16'd0, StallCycles}, 3);
    EX_Rd = 0;
    chk_out("load_use_rd0", 4'b1100);
    ID_Rt = 0;
    chk_out("load_use_both_r0", 4'b1100);
    cyc();
    chk("r0_no_count", {16'd0, StallCycles}, 3);
    idle();

    // Branch on a load in MEM: one stall, then taken.
    ID_Branch = 1; CompTaken = 1; ID_ReadsRs = 1; ID_Rs = 7; MEM_MemRead = 1; MEM_Rd = 7;
    chk_out("mem_load_stall", 4'b0001);
    cyc();
    MEM_MemRead = 0;
    chk_out("mem_resolve_taken", 4'b1110);
    cyc();
    idle();
    chk_cnt("after_mem", 3, 2, 4);
    cyc();

    // Jump with a load-use pattern never stalls.
    ID_Jump = 1; ID_ReadsRs = 1; ID_Rs = 2; EX_MemRead = 1; EX_Rd = 2;
    chk_out("jump_no_stall", 4'b1110);
    cyc();
    idle();
    chk_cnt("after_jump", 4, 3, 4);
    chk_out("jump_shadow", 4'b1100);
    cyc();

    // Freeze during STALL holds everything; one stall cycle remains afterwards.
    ID_Branch = 1; ID_ReadsRs = 1; ID_Rs = 4; EX_MemRead = 1; EX_Rd = 4;
    chk_out("freeze_pre_stall", 4'b0001);
    cyc();
    Freeze = 1;
    for (int i = 0; i < 3; i++) begin
      chk_out("freeze_outputs", 4'b0000);
      cyc();
    end
    chk_cnt("during_freeze", 4, 3, 5);
    Freeze = 0;
    chk_out("stall_after_freeze", 4'b0001);
    cyc();
    idle();
    chk_cnt("after_freeze", 4, 3, 6);
    chk_out("run_after_freeze", 4'b1100);
    cyc();

    // Branch and jump together count as one jump, even with a hazard present.
    ID_Branch = 1; ID_Jump = 1; ID_ReadsRs = 1; ID_Rs = 6; EX_MemRead = 1; EX_Rd = 6;
    chk_out("branch_and_jump", 4'b1110);
    cyc();
    idle();
    chk_cnt("after_both", 5, 4, 6);
    cyc();

    // Drive the 4-bit counters into saturation with 16 jumps.
    for (int i = 0; i < 16; i++) begin
      ID_Jump = 1;
      cyc();
      ID_Jump = 0;
      cyc();
    end
    chk_cnt("after_16_jumps", 21, 20, 6);
    chk("small_flush_sat", {28'd0, s_FlushCount}, 15);
    chk("small_branch_sat", {28'd0, s_BranchCount}, 15);
    chk("small_stall", {28'd0, s_StallCycles}, 6);
    ID_Jump = 1;
    #1;
    chk("small_flush_out", {31'd0, s_IFID_Flush}, 1);
    cyc();
    ID_Jump = 0;
    chk("small_flush_hold", {28'd0, s_FlushCount}, 15);
    chk("big_flush_inc", {16'd0, FlushCount}, 21);
    cyc();

    // Reset in the middle of a depth-2 stall abandons it.
    ID_Branch = 1; ID_ReadsRs = 1; ID_Rs = 9; EX_MemRead = 1; EX_Rd = 9;
    chk_out("pre_reset_stall", 4'b0001);
    cyc();
    reset = 1;
    chk_out("reset_mid_stall", 4'b0011);
    cyc();
    reset = 0;
    idle();
    chk_cnt("after_mid_reset", 0, 0, 0);
    chk_out("run_after_mid_reset", 4'b1100);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
- Sequences the ID-stage branch comparator and its surrounding pipeline registers in the 5-stage 16-bit datapath.
- Detects operand hazards on branch compares and load-use hazards, and stalls PC and IF/ID for the required number of cycles.
- Flushes IF/ID when a branch or jump resolves taken.
- Keeps saturating performance counters for branches, flushes and stall cycles.

Parameters:
REG_AW, 4, register-address width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Freeze  in  1  external global hold (memory wait); highest priority after reset
ID_Branch  in  1  conditional branch in ID
ID_Jump  in  1  unconditional jump in ID
ID_ReadsRs  in  1  ID instruction reads Rs
ID_ReadsRt  in  1  ID instruction reads Rt
ID_Rs  in  REG_AW  source register 1 in ID
ID_Rt  in  REG_AW  source register 2 in ID
EX_RegWrite  in  1  EX-stage instruction writes a register
EX_MemRead  in  1  EX-stage instruction is a load
EX_Rd  in  REG_AW  EX-stage destination register
MEM_MemRead  in  1  MEM-stage instruction is a load
MEM_Rd  in  REG_AW  MEM-stage destination register
CompTaken  in  1  comparator condition-true flag for the ID branch
PCWrite  out  1  PC may update
IFID_Write  out  1  IF/ID register may load
IFID_Flush  out  1  clear IF/ID to a bubble
IDEX_Bubble  out  1  insert a bubble into ID/EX
BranchCount  out  CNT_W  resolved branches and jumps
FlushCount  out  CNT_W  flushes issued
StallCycles  out  CNT_W  cycles spent stalled

Behaviour:
- Match(x, r) means: read-enable x is 1, r equals the ID source register, and r is nonzero. Register 0 never causes a hazard.
- Depth computation in state RUN:
  - Depth 2: ID_Branch=1 and EX_MemRead=1 with a match on EX_Rd.
  - Depth 1 (branch): ID_Branch=1 and EX_RegWrite=1 with a match on EX_Rd, and the instruction is not a load.
  - Depth 1 (branch): ID_Branch=1 and MEM_MemRead=1 with a match on MEM_Rd.
  - Depth 1 (load-use): any ID instruction with EX_MemRead=1 and a match on EX_Rd.
  - Depth 0: none of the above. ID_Jump never stalls.
- States:
  - RUN: if depth is greater than 0, assert stall outputs this cycle. For depth 2, go to STALL with Rem=1; for depth 1, stay in RUN.
  - STALL: assert stall outputs, then return to RUN. RUN re-evaluates all hazards on the next cycle.
  - SHADOW: entered for one cycle after any flush. ID holds a bubble, so ID_Branch and ID_Jump are ignored and no hazard is raised. Then go to RUN.
- Stall outputs: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
- Resolution: in RUN with depth 0, the instruction resolves when ID_Branch or ID_Jump is 1.
  - Taken = (ID_Branch & CompTaken) | ID_Jump.
  - If taken: IFID_Flush=1, PCWrite=1, IFID_Write=1 (flush wins over the load), IDEX_Bubble=0; go to SHADOW.
  - If ID_Branch and ID_Jump are both 1, treat it as one jump: one BranchCount increment, one flush.
- Normal outputs (no stall, no flush): PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- Freeze=1: PCWrite=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=0. State and counters hold. No resolution, no counting. Freeze in STALL does not consume the remaining cycle.
- Reset cycle:
  - Outputs: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1.
  - Next state: RUN, Rem=0, all counters 0.
  - Reset mid-STALL or mid-SHADOW abandons the sequence.
- Counters update on the clock edge, one cycle after the event, and saturate at 2^CNT_W-1 (no wrap).
  - BranchCount: +1 per resolution.
  - FlushCount: +1 per flush.
  - StallCycles: +1 per cycle with stall outputs asserted (Freeze cycles excluded).
- Stall/flush outputs are combinational from state and inputs, with no latency. Counters have a latency of 1.

Test Plan:
- Reset, then ID_Branch=1, no hazards, CompTaken=1 -> same cycle IFID_Flush=1, PCWrite=1. Next cycle SHADOW; an ID_Branch=1 there is ignored. BranchCount=1, FlushCount=1.
- Branch on Rs=3 with EX_MemRead=1, EX_RegWrite=1, EX_Rd=3 -> 2 stall cycles. Third cycle (hazard inputs cleared) resolves; CompTaken=0 gives no flush. StallCycles=2, BranchCount=1.
- Non-branch ID reads Rt=5 with EX_MemRead=1, EX_Rd=5 -> 1 stall cycle (IDEX_Bubble=1). With EX_Rd=0 instead -> no stall.
- ID_Jump=1 while EX_MemRead=1, EX_Rd=ID_Rs -> no stall, immediate flush, FlushCount increments.
- Freeze=1 for 3 cycles during STALL -> all outputs held as specified, counters unchanged. After Freeze drops, 1 stall cycle remains.
- Preload counters to 0xFFFF with CNT_W=16 via repeated events; one more flush -> FlushCount stays 0xFFFF. Assert reset mid-STALL -> RUN, counters 0.
